keylock_code_ctrl: RTL and testbench
====================================

KEYLOCK_CODE_CTRL -- requirements
Module: keylock_code_ctrl

Interface
REQ-001 Parameter DEFAULT_PC, default 16'h0123, is the programming-code reset value: four BCD digits, most significant digit entered first.
REQ-002 Parameter DEFAULT_UC, default 16'h6543, is the user-code reset value, in the same format as DEFAULT_PC.
REQ-003 Parameter HALF_PERIOD, default 25000000, is the number of clk cycles between blink_led toggles.
REQ-004 Parameter NUM_TOGGLES, default 6, is the number of blink_led toggles before DoneBlink asserts.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port rdy, input, 1 bit: one-cycle strobe marking keypress as valid.
REQ-008 Port keypress, input, 4 bits: key code; 0-6 are data digits, 7 is abort, 8 is the program command, 9 is the lock command, 10-15 are ignored.
REQ-009 Ports CheckPC, CheckValidUC, confirmUC, LOCKING, ToggleLED1, Chillin and error, inputs, 1 bit each: state decodes from the keylock FSM.
REQ-010 Port match, output, 1 bit: the entry buffer equals the selected target code.
REQ-011 Port ValidUC, output, 1 bit: the entry buffer is acceptable as a new user code.
REQ-012 Port DoneBlink, output, 1 bit: one-cycle pulse when a blink sequence completes.
REQ-013 Port LED1, output, 1 bit: lock status; 1 means locked.
REQ-014 Port blink_led, output, 1 bit: blinking indicator.
REQ-015 Port digit_count, output, 3 bits: number of buffered digits, 0-4.

Function
REQ-016 rdy with keypress 0-6 and digit_count<4 shall shift the digit into entry_buf[3:0] (entry_buf <= {entry_buf[11:0], keypress}) and increment digit_count on the same edge.
REQ-017 rdy with keypress 0-6 and digit_count==4 shall be ignored: no shift, count saturates at 4.
REQ-018 rdy with keypress 7, 8 or 9 shall clear entry_buf to 0 and digit_count to 0 on that edge, after any register capture defined below.
REQ-019 rdy with keypress 10-15 shall have no effect.
REQ-020 error, Chillin or ToggleLED1 high shall clear entry_buf and digit_count each cycle; this clear has priority over digit entry.
REQ-021 match shall be combinational and equal (digit_count==4) & (entry_buf==target), so it is valid in the same cycle as the command strobe.
REQ-022 Target priority: CheckPC selects pc_reg; else confirmUC selects pend_reg; else uc_reg.
REQ-023 ValidUC shall be combinational and equal (digit_count==4) & (entry_buf!=pc_reg) & (entry_buf!=uc_reg).
REQ-024 rdy & keypress==8 & CheckValidUC & ValidUC shall load pend_reg with entry_buf.
REQ-025 rdy & keypress==8 & confirmUC & match shall load uc_reg with pend_reg; uc_reg shall change at no other time except reset.
REQ-026 pc_reg shall be constant at DEFAULT_PC.
REQ-027 LED1 shall toggle on every cycle in which ToggleLED1 is high; ToggleLED1 is a single-cycle state, so one toggle occurs per pass.
REQ-028 Blink timer states: IDLE and BLINK.
REQ-029 IDLE->BLINK when (error|Chillin)=1; blink_led is 1 on the entry cycle and the cycle counter starts at 0.
REQ-030 In BLINK, when the cycle counter reaches HALF_PERIOD-1, blink_led toggles, the counter wraps to 0, and the toggle counter increments.
REQ-031 On the toggle that makes the toggle count equal NUM_TOGGLES, DoneBlink shall pulse for exactly one cycle, the timer shall return to IDLE, and blink_led shall be 0.
REQ-032 If error and Chillin both drop while in BLINK, the timer shall abort to IDLE the next cycle, with blink_led=0, counters cleared, and no DoneBlink.
REQ-033 After DoneBlink, a new sequence shall start only if error|Chillin is still high after the timer has been in IDLE for one cycle.
REQ-034 The cycle counter shall be wide enough for HALF_PERIOD-1 and the toggle counter wide enough for NUM_TOGGLES.

Reset
REQ-035 When reset=1 at a clk edge: entry_buf=0, digit_count=0, pc_reg=DEFAULT_PC, uc_reg=DEFAULT_UC, pend_reg=0, LED1=0, blink_led=0, DoneBlink=0, timer IDLE, counters 0.
REQ-036 Reset shall override all other activity, including reset mid-entry and mid-blink.
REQ-037 With digit_count=0 out of reset, match=0 and ValidUC=0.

Verification
REQ-038 Scenario (unlock): with LOCKING=1, enter 6,5,4,3 then 9 -> match=1 on the cycle of the 9 strobe; digit_count=0 on the next cycle.
REQ-039 Scenario (overflow): enter 6,5,4,3,2 then 9 -> entry_buf=16'h6543 and match=1, because the fifth digit is ignored.
REQ-040 Scenario (reprogram): CheckPC with 0,1,2,3,8 gives match=1; CheckValidUC with 1,1,2,2,8 gives ValidUC=1 and pend_reg=16'h1122; confirmUC with 1,1,2,2,8 gives match=1 and uc_reg=16'h1122 on the next cycle.
REQ-041 Scenario (reject): CheckValidUC with 0,1,2,3 -> ValidUC=0, because the entry equals pc_reg.
REQ-042 Scenario (blink): HALF_PERIOD=4, NUM_TOGGLES=6, error held high -> blink_led toggles every 4 cycles, DoneBlink pulses once 24 cycles after entry, then blink_led=0.
REQ-043 Scenario (abort and reset): error dropped mid-blink -> no DoneBlink and IDLE next cycle; reset asserted after 2 digits -> digit_count=0, and uc_reg back to DEFAULT_UC after a prior reprogram.

Source files
------------

// File: rtl/keylock_code_ctrl.sv
// Code-entry datapath and blink timer for the keylock: buffers up to four BCD
// digits, compares them against the programming/user codes and times the LED blink.
module keylock_code_ctrl #(
    parameter logic [15:0] DEFAULT_PC  = 16'h0123,
    parameter logic [15:0] DEFAULT_UC  = 16'h6543,
    parameter int          HALF_PERIOD = 25000000,
    parameter int          NUM_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic [3:0] keypress,
    input  logic       CheckPC,
    input  logic       CheckValidUC,
    input  logic       confirmUC,
    input  logic       LOCKING,
    input  logic       ToggleLED1,
    input  logic       Chillin,
    input  logic       error,
    output logic       match,
    output logic       ValidUC,
    output logic       DoneBlink,
    output logic       LED1,
    output logic       blink_led,
    output logic [2:0] digit_count
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int TOG_W = (NUM_TOGGLES > 0) ? $clog2(NUM_TOGGLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(NUM_TOGGLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } blink_state_t;

    // LOCKING only sequences the outer FSM; nothing here depends on it.
    logic unused_locking;
    assign unused_locking = LOCKING;

    // Entry buffer and stored codes
    logic [15:0] entry_buf_reg, entry_buf_next;
    logic [2:0]  digit_count_reg, digit_count_next;
    logic [15:0] uc_reg, uc_next;
    logic [15:0] pend_reg, pend_next;
    logic [15:0] pc_reg;
    logic        led1_reg, led1_next;

    // Blink timer
    blink_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cyc_reg, cyc_next;
    logic [TOG_W-1:0] tog_reg, tog_next;
    logic             blink_reg, blink_next;
    logic             done_reg, done_next;

    logic        is_digit, is_cmd, is_prog, buf_full, clear_all, blink_req;
    logic [15:0] target_code;
    logic [3:0]  tgt_eq, pc_eq, uc_eq;

    assign pc_reg    = DEFAULT_PC;
    assign is_digit  = (keypress <= 4'd6);
    assign is_cmd    = (keypress >= 4'd7) && (keypress <= 4'd9);
    assign is_prog   = rdy && (keypress == 4'd8);
    assign buf_full  = (digit_count_reg == 3'd4);
    assign clear_all = error | Chillin | ToggleLED1;
    assign blink_req = error | Chillin;

    always_comb begin
        target_code = uc_reg;
        if (CheckPC) begin
            target_code = pc_reg;
        end else if (confirmUC) begin
            target_code = pend_reg;
        end
    end

    // Nibble-wise comparators against the selected target and both stored codes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
            assign tgt_eq[gi] = (entry_buf_reg[gi*4 +: 4] == target_code[gi*4 +: 4]);
            assign pc_eq[gi]  = (entry_buf_reg[gi*4 +: 4] == pc_reg[gi*4 +: 4]);
            assign uc_eq[gi]  = (entry_buf_reg[gi*4 +: 4] == uc_reg[gi*4 +: 4]);
        end
    endgenerate

    assign match   = buf_full & (&tgt_eq);
    assign ValidUC = buf_full & ~(&pc_eq) & ~(&uc_eq);

    always_comb begin
        entry_buf_next   = entry_buf_reg;
        digit_count_next = digit_count_reg;
        pend_next        = pend_reg;
        uc_next          = uc_reg;
        led1_next        = led1_reg;

        // Code registers capture from the current buffer before any clear below
        if (is_prog && CheckValidUC && ValidUC) begin
            pend_next = entry_buf_reg;
        end
        if (is_prog && confirmUC && match) begin
            uc_next = pend_reg;
        end
        if (ToggleLED1) begin
            led1_next = ~led1_reg;
        end

        if (clear_all || (rdy && is_cmd)) begin
            entry_buf_next   = 16'h0000;
            digit_count_next = 3'd0;
        end else if (rdy && is_digit && !buf_full) begin
            entry_buf_next   = {entry_buf_reg[11:0], keypress};
            digit_count_next = digit_count_reg + 3'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        tog_next   = tog_reg;
        blink_next = blink_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (blink_req) begin
                    state_next = BLINK;
                    cyc_next   = '0;
                    tog_next   = '0;
                    blink_next = 1'b1;
                end
            end
            BLINK: begin
                if (!blink_req) begin
                    state_next = IDLE;
                    cyc_next   = '0;
                    tog_next   = '0;
                    blink_next = 1'b0;
                end else if (cyc_reg == CNT_MAX) begin
                    cyc_next = '0;
                    if (tog_reg == TOG_LAST) begin
                        // Final toggle: finish with the LED dark and pulse done
                        state_next = IDLE;
                        tog_next   = '0;
                        blink_next = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        tog_next   = tog_reg + TOG_W'(1);
                        blink_next = ~blink_reg;
                    end
                end else begin
                    cyc_next = cyc_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = '0;
                tog_next   = '0;
                blink_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_buf_reg   <= 16'h0000;
            digit_count_reg <= 3'd0;
            uc_reg          <= DEFAULT_UC;
            pend_reg        <= 16'h0000;
            led1_reg        <= 1'b0;
            state_reg       <= IDLE;
            cyc_reg         <= '0;
            tog_reg         <= '0;
            blink_reg       <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            entry_buf_reg   <= entry_buf_next;
            digit_count_reg <= digit_count_next;
            uc_reg          <= uc_next;
            pend_reg        <= pend_next;
            led1_reg        <= led1_next;
            state_reg       <= state_next;
            cyc_reg         <= cyc_next;
            tog_reg         <= tog_next;
            blink_reg       <= blink_next;
            done_reg        <= done_next;
        end
    end

    assign DoneBlink   = done_reg;
    assign LED1        = led1_reg;
    assign blink_led   = blink_reg;
    assign digit_count = digit_count_reg;

endmodule

// File: tb/tb_keylock_code_ctrl.sv
// Directed bench for keylock_code_ctrl: code entry, reprogramming, LED toggle and
// blink timing with HALF_PERIOD=4, NUM_TOGGLES=6.
module tb_keylock_code_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rdy = 1'b0;
    logic [3:0] keypress = 4'd0;
    logic       CheckPC = 1'b0, CheckValidUC = 1'b0, confirmUC = 1'b0, LOCKING = 1'b0;
    logic       ToggleLED1 = 1'b0, Chillin = 1'b0, error = 1'b0;
    logic       match, ValidUC, DoneBlink, LED1, blink_led;
    logic [2:0] digit_count;

    int vectors = 0;
    int miscompares = 0;

    keylock_code_ctrl #(
        .DEFAULT_PC (16'h0123),
        .DEFAULT_UC (16'h6543),
        .HALF_PERIOD(4),
        .NUM_TOGGLES(6)
    ) dut (
        .clk(clk), .reset(reset), .rdy(rdy), .keypress(keypress),
        .CheckPC(CheckPC), .CheckValidUC(CheckValidUC), .confirmUC(confirmUC),
        .LOCKING(LOCKING), .ToggleLED1(ToggleLED1), .Chillin(Chillin), .error(error),
        .match(match), .ValidUC(ValidUC), .DoneBlink(DoneBlink), .LED1(LED1),
        .blink_led(blink_led), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        rdy = 1'b1;
        keypress = k;
        tick();
        rdy = 1'b0;
        keypress = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (digit_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
        vectors++;
        if (match !== 1'b0 || ValidUC !== 1'b0) begin miscompares++; $display("FAIL reset_cmp got match=%b valid=%b exp=0/0", match, ValidUC); end
        vectors++;
        if (LED1 !== 1'b0 || blink_led !== 1'b0 || DoneBlink !== 1'b0) begin
            miscompares++; $display("FAIL reset_leds got led1=%b blink=%b done=%b exp=000", LED1, blink_led, DoneBlink);
        end
        $display("test_reset done");
    endtask

    task automatic test_unlock();
        logic [3:0] seq [4] = '{4'd6, 4'd5, 4'd4, 4'd3};
        LOCKING = 1'b1;
        for (int i = 0; i < 4; i++) begin
            press(seq[i]);
            vectors++;
            if (digit_count !== 3'(i + 1)) begin miscompares++; $display("FAIL unlock_count[%0d] got=%0d exp=%0d", i, digit_count, i + 1); end
        end
        rdy = 1'b1; keypress = 4'd9;
        #1;
        vectors++;
        if (match !== 1'b1) begin miscompares++; $display("FAIL unlock_match got=%b exp=1", match); end
        tick();
        rdy = 1'b0;
        vectors++;
        if (digit_count !== 3'd0 || match !== 1'b0) begin miscompares++; $display("FAIL unlock_clear got count=%0d match=%b exp=0/0", digit_count, match); end
        LOCKING = 1'b0;
        $display("test_unlock done");
    endtask

    task automatic test_overflow();
        logic [3:0] seq [5] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
        LOCKING = 1'b1;
        for (int i = 0; i < 5; i++) press(seq[i]);
        vectors++;
        if (digit_count !== 3'd4) begin miscompares++; $display("FAIL overflow_count got=%0d exp=4", digit_count); end
        rdy = 1'b1; keypress = 4'd9;
        #1;
        vectors++;
        if (match !== 1'b1) begin miscompares++; $display("FAIL overflow_match got=%b exp=1", match); end
        tick();
        rdy = 1'b0;
        LOCKING = 1'b0;
        $display("test_overflow done");
    endtask

    task automatic test_ignored_keys();
        press(4'd1);
        press(4'd2);
        press(4'd12);
        press(4'd15);
        vectors++;
        if (digit_count !== 3'd2) begin miscompares++; $display("FAIL ignored_count got=%0d exp=2", digit_count); end
        press(4'd7);
        vectors++;
        if (digit_count !== 3'd0) begin miscompares++; $display("FAIL abort_clear got=%0d exp=0", digit_count); end
        $display("test_ignored_keys done");
    endtask

    task automatic test_toggle_clear();
        press(4'd4);
        press(4'd4);
        ToggleLED1 = 1'b1;
        press(4'd3);
        ToggleLED1 = 1'b0;
        vectors++;
        if (digit_count !== 3'd0) begin miscompares++; $display("FAIL toggle_clear got=%0d exp=0", digit_count); end
        vectors++;
        if (LED1 !== 1'b1) begin miscompares++; $display("FAIL led1_on got=%b exp=1", LED1); end
        ToggleLED1 = 1'b1;
        tick();
        ToggleLED1 = 1'b0;
        vectors++;
        if (LED1 !== 1'b0) begin miscompares++; $display("FAIL led1_off got=%b exp=0", LED1); end
        $display("test_toggle_clear done");
    endtask

    task automatic test_reprogram();
        logic [3:0] pc_seq [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [3:0] nu_seq [4] = '{4'd1, 4'd1, 4'd2, 4'd2};
        logic [3:0] old_seq [4] = '{4'd6, 4'd5, 4'd4, 4'd3};
        CheckPC = 1'b1;
        for (int i = 0; i < 4; i++) press(pc_seq[i]);
        rdy = 1'b1; keypress = 4'd8;
        #1;
        vectors++;
        if (match !== 1'b1) begin miscompares++; $display("FAIL pc_match got=%b exp=1", match); end
        tick();
        rdy = 1'b0; CheckPC = 1'b0;

        CheckValidUC = 1'b1;
        for (int i = 0; i < 4; i++) press(nu_seq[i]);
        vectors++;
        if (ValidUC !== 1'b1) begin miscompares++; $display("FAIL valid_uc got=%b exp=1", ValidUC); end
        press(4'd8);
        CheckValidUC = 1'b0;

        confirmUC = 1'b1;
        for (int i = 0; i < 4; i++) press(nu_seq[i]);
        rdy = 1'b1; keypress = 4'd8;
        #1;
        vectors++;
        if (match !== 1'b1) begin miscompares++; $display("FAIL confirm_match got=%b exp=1", match); end
        tick();
        rdy = 1'b0; confirmUC = 1'b0;

        for (int i = 0; i < 4; i++) press(nu_seq[i]);
        vectors++;
        if (match !== 1'b1) begin miscompares++; $display("FAIL new_uc_match got=%b exp=1", match); end
        press(4'd7);
        for (int i = 0; i < 4; i++) press(old_seq[i]);
        vectors++;
        if (match !== 1'b0) begin miscompares++; $display("FAIL old_uc_match got=%b exp=0", match); end
        press(4'd7);
        $display("test_reprogram done");
    endtask

    task automatic test_reject();
        logic [3:0] pc_seq [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [3:0] uc_seq [4] = '{4'd1, 4'd1, 4'd2, 4'd2};
        logic [3:0] ok_seq [4] = '{4'd2, 4'd2, 4'd3, 4'd3};
        CheckValidUC = 1'b1;
        for (int i = 0; i < 4; i++) press(pc_seq[i]);
        vectors++;
        if (ValidUC !== 1'b0) begin miscompares++; $display("FAIL reject_pc got=%b exp=0", ValidUC); end
        press(4'd7);
        for (int i = 0; i < 4; i++) press(uc_seq[i]);
        vectors++;
        if (ValidUC !== 1'b0) begin miscompares++; $display("FAIL reject_uc got=%b exp=0", ValidUC); end
        press(4'd7);
        for (int i = 0; i < 3; i++) press(ok_seq[i]);
        vectors++;
        if (ValidUC !== 1'b0) begin miscompares++; $display("FAIL reject_short got=%b exp=0", ValidUC); end
        press(ok_seq[3]);
        vectors++;
        if (ValidUC !== 1'b1) begin miscompares++; $display("FAIL accept_new got=%b exp=1", ValidUC); end
        press(4'd7);
        CheckValidUC = 1'b0;
        $display("test_reject done");
    endtask

    task automatic test_blink();
        logic exp_blink;
        press(4'd5);
        error = 1'b1;
        tick();
        vectors++;
        if (blink_led !== 1'b1 || digit_count !== 3'd0) begin
            miscompares++; $display("FAIL blink_entry got blink=%b count=%0d exp=1/0", blink_led, digit_count);
        end
        for (int n = 1; n <= 24; n++) begin
            tick();
            exp_blink = (n == 24) ? 1'b0 : (((n / 4) % 2) == 0);
            vectors++;
            if (blink_led !== exp_blink || DoneBlink !== (n == 24)) begin
                miscompares++;
                $display("FAIL blink_cycle[%0d] got blink=%b done=%b exp=%b/%b", n, blink_led, DoneBlink, exp_blink, n == 24);
            end
        end
        tick();
        vectors++;
        if (blink_led !== 1'b1 || DoneBlink !== 1'b0) begin
            miscompares++; $display("FAIL blink_restart got blink=%b done=%b exp=1/0", blink_led, DoneBlink);
        end
        error = 1'b0;
        tick();
        vectors++;
        if (blink_led !== 1'b0 || DoneBlink !== 1'b0) begin
            miscompares++; $display("FAIL blink_stop got blink=%b done=%b exp=0/0", blink_led, DoneBlink);
        end
        $display("test_blink done");
    endtask

    task automatic test_abort();
        int dones;
        Chillin = 1'b1;
        for (int n = 0; n < 7; n++) tick();
        vectors++;
        if (blink_led !== 1'b0) begin miscompares++; $display("FAIL abort_mid got blink=%b exp=0", blink_led); end
        Chillin = 1'b0;
        dones = 0;
        tick();
        vectors++;
        if (blink_led !== 1'b0 || DoneBlink !== 1'b0) begin
            miscompares++; $display("FAIL abort_idle got blink=%b done=%b exp=0/0", blink_led, DoneBlink);
        end
        for (int n = 0; n < 30; n++) begin
            tick();
            if (DoneBlink === 1'b1 || blink_led === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin miscompares++; $display("FAIL abort_quiet got active_cycles=%0d exp=0", dones); end
        $display("test_abort done");
    endtask

    task automatic test_reset_mid();
        logic [3:0] old_seq [4] = '{4'd6, 4'd5, 4'd4, 4'd3};
        press(4'd1);
        press(4'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (digit_count !== 3'd0) begin miscompares++; $display("FAIL reset_mid_count got=%0d exp=0", digit_count); end
        for (int i = 0; i < 4; i++) press(old_seq[i]);
        vectors++;
        if (match !== 1'b1) begin miscompares++; $display("FAIL reset_uc_restore got match=%b exp=1", match); end
        press(4'd7);
        error = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        reset = 1'b1;
        error = 1'b0;
        tick();
        reset = 1'b0;
        vectors++;
        if (blink_led !== 1'b0 || DoneBlink !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_blink got blink=%b done=%b exp=0/0", blink_led, DoneBlink);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_overflow();
        test_ignored_keys();
        test_toggle_clear();
        test_reprogram();
        test_reject();
        test_blink();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
